// File: rtl/sp_fifo_pkg.sv
// rtl/sp_fifo_pkg.sv - shared types and helpers for the single-port FIFO
package sp_fifo_pkg;

    // Which access owns the single RAM port this cycle.
    typedef enum logic [1:0] {
        ACC_IDLE = 2'd0,
        ACC_WR   = 2'd1,
        ACC_RD   = 2'd2
    } acc_e;

    // Number of RAM entries for a given address width.
    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    // Occupancy from extended pointers; the subtraction wraps modulo
    // 2**(addr_w+1), so it is correct across pointer wrap.
    function automatic logic [31:0] fifo_count(input logic [31:0] wptr,
                                               input logic [31:0] rptr,
                                               input int          addr_w);
        logic [31:0] mask;
        mask = (32'd1 << (addr_w + 1)) - 32'd1;
        return (wptr - rptr) & mask;
    endfunction

endpackage

// File: rtl/sp_fifo_ram.sv
// rtl/sp_fifo_ram.sv - single-port RAM with registered read data
//
// Ports:
//   clk, reset : clock, asynchronous active-high reset (clears dout only)
//   en, we     : access enable, write enable (read when en & !we)
//   addr, din  : address and write data
//   dout       : registered read data, holds when no read is performed
module sp_fifo_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Storage is not reset; only the output register is.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= din;
        end
    end

    // Writes do not update dout (no write-through).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout <= '0;
        end else if (en && !we) begin
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/sp_fifo_arb.sv
// rtl/sp_fifo_arb.sv - single-port-RAM FIFO with write-priority arbitration
//
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   sclr              : synchronous clear, overrides all accesses
//   wr_en, din        : write request and data
//   rd_en             : read request
//   dout, rd_valid    : read data, valid the cycle after rd_ack
//   wr_ack, rd_ack    : combinational accept strobes
//   full, empty, almost_full, almost_empty, count : status from pointers
//   overflow, underflow : registered error strobes
//
// Build option: SP_FIFO_STICKY_ERR_EN makes overflow/underflow sticky until
// reset or sclr; otherwise they are one-cycle pulses.
module sp_fifo_arb
    import sp_fifo_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              rd_valid,
    output logic              wr_ack,
    output logic              rd_ack,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH    = depth_of(ADDR_W);
    localparam int AF_CLAMP = (AF_LEVEL > DEPTH) ? DEPTH : AF_LEVEL;
    localparam logic [ADDR_W:0] AF_THR = (ADDR_W + 1)'(AF_CLAMP);
    localparam logic [ADDR_W:0] AE_THR = (ADDR_W + 1)'(AE_LEVEL);

    logic [ADDR_W:0]   wptr;
    logic [ADDR_W:0]   rptr;
    logic [ADDR_W-1:0] ram_addr;
    logic              ovf_ev;
    logic              udf_ev;
    acc_e              acc;

    // The extra pointer MSB distinguishes full from empty so all
    // 2**ADDR_W entries are usable.
    assign empty        = (wptr == rptr);
    assign full         = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                          (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
    assign count        = (ADDR_W + 1)'(fifo_count(32'(wptr), 32'(rptr), ADDR_W));
    assign almost_full  = (count >= AF_THR);
    assign almost_empty = (count <= AE_THR);

    // A read that loses to a write is a stall, so it raises no underflow.
    always_comb begin
        wr_ack   = wr_en & ~full & ~sclr;
        rd_ack   = rd_en & ~empty & ~sclr & ~wr_ack;
        ovf_ev   = wr_en & full & ~sclr;
        udf_ev   = rd_en & empty & ~wr_ack & ~sclr;
        acc      = ACC_IDLE;
        ram_addr = '0;
        if (wr_ack) begin
            acc = ACC_WR;
        end else if (rd_ack) begin
            acc = ACC_RD;
        end
        case (acc)
            ACC_WR:  ram_addr = wptr[ADDR_W-1:0];
            ACC_RD:  ram_addr = rptr[ADDR_W-1:0];
            default: ram_addr = '0;
        endcase
    end

    sp_fifo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .en    (acc != ACC_IDLE),
        .we    (acc == ACC_WR),
        .addr  (ram_addr),
        .din   (din),
        .dout  (dout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (sclr) begin
            wptr      <= '0;
            rptr      <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wptr     <= wptr + (ADDR_W + 1)'(wr_ack);
            rptr     <= rptr + (ADDR_W + 1)'(rd_ack);
            rd_valid <= rd_ack;
`ifdef SP_FIFO_STICKY_ERR_EN
            overflow  <= overflow | ovf_ev;
            underflow <= underflow | udf_ev;
`else
            overflow  <= ovf_ev;
            underflow <= udf_ev;
`endif
        end
    end

endmodule

// File: tb/tb_sp_fifo_arb.sv
// tb/tb_sp_fifo_arb.sv - self-checking bench for sp_fifo_arb
module tb_sp_fifo_arb;

    localparam int DEPTH = 8;

    logic       clk;
    logic       reset;
    logic       sclr;
    logic       wr_en;
    logic [7:0] din;
    logic       rd_en;
    logic [7:0] dout;
    logic       rd_valid;
    logic       wr_ack;
    logic       rd_ack;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    sp_fifo_arb #(
        .DATA_W   (8),
        .ADDR_W   (3),
        .AF_LEVEL (6),
        .AE_LEVEL (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sclr         (sclr),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .dout         (dout),
        .rd_valid     (rd_valid),
        .wr_ack       (wr_ack),
        .rd_ack       (rd_ack),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a plain queue of stored bytes plus the last read data.
    logic [7:0] mq[$];
    logic [7:0] m_dout;
    bit         m_rdv;
    bit         m_ovf;
    bit         m_udf;

    // Accept strobes sampled mid-cycle by the last cyc call.
    bit s_wa;
    bit s_ra;

    typedef struct {
        bit         wr;
        bit         rd;
        logic [7:0] d;
        bit         ewa;
        bit         era;
        int         cnt;
        bit         efull;
        bit         eaf;
        bit         erdv;
        logic [7:0] edout;
        bit         eovf;
        bit         eudf;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_state();
        int n;
        n = mq.size();
        chk("count", 32'(count), 32'(n));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("almost_full", 32'(almost_full), 32'(n >= 6));
        chk("almost_empty", 32'(almost_empty), 32'(n <= 1));
        chk("rd_valid", 32'(rd_valid), 32'(m_rdv));
        chk("dout", 32'(dout), 32'(m_dout));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_udf));
    endtask

    // Called at posedge+1; drives one cycle, checks strobes mid-cycle and
    // registered state just after the next rising edge.
    task automatic cyc(input bit w, input bit r, input logic [7:0] d, input bit sc);
        bit mfull, mempty, ewa, era, ovf_ev, udf_ev;
        wr_en = w;
        rd_en = r;
        din   = d;
        sclr  = sc;
        mfull  = (mq.size() == DEPTH);
        mempty = (mq.size() == 0);
        ewa    = w && !mfull && !sc;
        era    = r && !mempty && !sc && !ewa;
        ovf_ev = w && mfull && !sc;
        udf_ev = r && mempty && !ewa && !sc;
        #4;
        s_wa = wr_ack;
        s_ra = rd_ack;
        chk("wr_ack", 32'(wr_ack), 32'(ewa));
        chk("rd_ack", 32'(rd_ack), 32'(era));
        @(posedge clk);
        #1;
        if (sc) begin
            mq.delete();
            m_rdv = 1'b0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (ewa) mq.push_back(d);
            if (era) m_dout = mq.pop_front();
            m_rdv = era;
`ifdef SP_FIFO_STICKY_ERR_EN
            m_ovf = m_ovf | ovf_ev;
            m_udf = m_udf | udf_ev;
`else
            m_ovf = ovf_ev;
            m_udf = udf_ev;
`endif
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        sclr  = 1'b0;
        check_state();
    endtask

    initial begin
        int n_w;
        int n_r;

        // Tests 1 and 2 as explicit vectors: 8 writes, overflow, 8 reads, underflow.
        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{1'b1, 1'b0, 8'(8'h10 + i), 1'b1, 1'b0, i + 1,
                       (i == 7), (i + 1 >= 6), 1'b0, 8'h00, 1'b0, 1'b0};
        end
        tbl[8] = '{1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 8, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        for (int k = 0; k < 8; k++) begin
            tbl[9 + k] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 7 - k,
                           1'b0, (7 - k >= 6), 1'b1, 8'(8'h10 + k), 1'b0, 1'b0};
        end
        tbl[17] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 8'h17, 1'b0, 1'b1};

        m_dout = 8'h00;
        m_rdv  = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        reset  = 1'b1;
        sclr   = 1'b0;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        din    = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_state();
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].wr, tbl[i].rd, tbl[i].d, 1'b0);
            chk($sformatf("t%0d_wr_ack", i), 32'(s_wa), 32'(tbl[i].ewa));
            chk($sformatf("t%0d_rd_ack", i), 32'(s_ra), 32'(tbl[i].era));
            chk($sformatf("t%0d_count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("t%0d_full", i), 32'(full), 32'(tbl[i].efull));
            chk($sformatf("t%0d_empty", i), 32'(empty), 32'(tbl[i].cnt == 0));
            chk($sformatf("t%0d_af", i), 32'(almost_full), 32'(tbl[i].eaf));
            chk($sformatf("t%0d_rd_valid", i), 32'(rd_valid), 32'(tbl[i].erdv));
            chk($sformatf("t%0d_dout", i), 32'(dout), 32'(tbl[i].edout));
            if (tbl[i].eovf) chk($sformatf("t%0d_overflow", i), 32'(overflow), 32'd1);
            if (tbl[i].eudf) chk($sformatf("t%0d_underflow", i), 32'(underflow), 32'd1);
        end

        // Test 3: simultaneous request with room: write wins, read stalls.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(8'h31 + i), 1'b0);
        cyc(1'b1, 1'b1, 8'hA5, 1'b0);
        chk("t3_wr_ack", 32'(s_wa), 32'd1);
        chk("t3_rd_ack", 32'(s_ra), 32'd0);
        chk("t3_count", 32'(count), 32'd4);
        chk("t3_rd_valid", 32'(rd_valid), 32'd0);
        chk("t3_underflow", 32'(underflow), 32'd0);
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        chk("t3_rd_valid2", 32'(rd_valid), 32'd1);
        chk("t3_dout", 32'(dout), 32'h31);

        // Test 4: full FIFO with both requests: read proceeds, write overflows.
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
        chk("t4_full", 32'(full), 32'd1);
        cyc(1'b1, 1'b1, 8'hEE, 1'b0);
        chk("t4_rd_ack", 32'(s_ra), 32'd1);
        chk("t4_wr_ack", 32'(s_wa), 32'd0);
        chk("t4_count", 32'(count), 32'd7);
        chk("t4_overflow", 32'(overflow), 32'd1);
        chk("t4_rd_valid", 32'(rd_valid), 32'd1);
        chk("t4_dout", 32'(dout), 32'h32);

        // Test 5: random traffic until both pointers have wrapped 3 times.
        n_w = 0;
        n_r = 0;
        for (int i = 0; i < 400 && (i < 40 || n_w < 24 || n_r < 24); i++) begin
            cyc($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 65, 8'($urandom), 1'b0);
            n_w += int'(s_wa);
            n_r += int'(s_ra);
            chk("t5_count_le_depth", 32'(count <= 4'd8), 32'd1);
            chk("t5_not_full_and_empty", 32'(full && empty), 32'd0);
        end
        chk("t5_write_wraps", 32'(n_w >= 24), 32'd1);
        chk("t5_read_wraps", 32'(n_r >= 24), 32'd1);

        // Test 6: sclr with a read in flight.
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        chk("t6_count5", 32'(count), 32'd5);
        chk("t6_rd_inflight", 32'(rd_valid), 32'd1);
        cyc(1'b0, 1'b1, 8'h00, 1'b1);
        chk("t6_sclr_count", 32'(count), 32'd0);
        chk("t6_sclr_empty", 32'(empty), 32'd1);
        chk("t6_sclr_rd_valid", 32'(rd_valid), 32'd0);
        chk("t6_sclr_dout_hold", 32'(dout), 32'h60);

        // Reset mid-write with overflow and a read in flight; no clock edge.
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'(8'h70 + i), 1'b0);
        cyc(1'b1, 1'b1, 8'hCD, 1'b0);
        chk("t6_pre_overflow", 32'(overflow), 32'd1);
        chk("t6_pre_rd_valid", 32'(rd_valid), 32'd1);
        wr_en = 1'b1;
        din   = 8'h77;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_almost_empty", 32'(almost_empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        mq.delete();
        m_dout = 8'h00;
        m_rdv  = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        wr_en  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Post-reset sanity: the in-flight write was discarded.
        cyc(1'b1, 1'b0, 8'h99, 1'b0);
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        chk("post_rst_dout", 32'(dout), 32'h99);
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        chk("post_rst_underflow", 32'(underflow), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sp_fifo_arb.md
Name: sp_fifo_arb

Overview:
- Parametrised synchronous FIFO built on one single-port RAM. One RAM access per cycle.
- Arbitrates write-vs-read with write priority. Uses the full 2**ADDR_W depth through extended pointers.
- Adds occupancy count, almost-full/almost-empty thresholds, accept strobes and error strobes.
- Drop-in buffer for byte/word streams between datapath stages in the lab designs.

Parameters:
- DATA_W, 8, data width in bits
- ADDR_W, 3, RAM address width; DEPTH = 2**ADDR_W entries
- AF_LEVEL, 6, almost_full asserted when count >= AF_LEVEL (1..DEPTH)
- AE_LEVEL, 1, almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- sclr  in  1  synchronous clear, active-high
- wr_en  in  1  write request
- din  in  DATA_W  write data
- rd_en  in  1  read request
- dout  out  DATA_W  read data, registered RAM output
- rd_valid  out  1  dout holds data from the read accepted last cycle
- wr_ack  out  1  combinational: write accepted this cycle
- rd_ack  out  1  combinational: read accepted this cycle
- full, empty, almost_full, almost_empty  out  1 each  status flags
- count  out  ADDR_W+1  occupancy, 0..DEPTH
- overflow  out  1  write request rejected because full
- underflow  out  1  read request rejected because empty

Behaviour:
- Clock and reset: clk is the clock; reset is asynchronous and active-high.
- Pointers:
  - wptr and rptr are ADDR_W+1 bits; the RAM address is the low ADDR_W bits.
  - count = wptr - rptr, modulo 2**(ADDR_W+1).
  - empty = (wptr == rptr).
  - full = MSBs differ and low bits equal.
  - Flags are combinational from registered pointers only, never from the current request.
- Arbitration, evaluated each cycle:
  - wr_ack = wr_en & !full & !sclr.
  - rd_ack = rd_en & !empty & !sclr & !wr_ack. Write has priority.
  - A read blocked by a write is a stall, not an error: no underflow, no rd_valid; requester holds rd_en.
  - When full, a simultaneous wr_en/rd_en performs the read; the write is rejected with an overflow strobe.
- RAM port: en = wr_ack | rd_ack; we = wr_ack; addr = wptr[ADDR_W-1:0] on write, rptr[ADDR_W-1:0] on read, else 0.
- Pointer updates: wptr increments on wr_ack, rptr increments on rd_ack, both wrapping naturally.
- Read latency is 1 cycle:
  - rd_valid <= rd_ack.
  - dout updates the cycle after rd_ack and holds its value when there is no read.
- Error strobes:
  - overflow = wr_en & full & !sclr, registered as a one-cycle pulse the next cycle.
  - underflow = rd_en & empty & !wr_ack & !sclr, with the same registered one-cycle pulse timing.
- sclr:
  - Has priority over all accesses.
  - Next cycle: wptr = rptr = 0, rd_valid = 0, overflow = underflow = 0.
  - RAM contents are not cleared; dout holds its value.
- Reset, asynchronous:
  - wptr = rptr = 0, dout = 0, rd_valid = 0, overflow = underflow = 0.
  - Resulting outputs: empty = 1, almost_empty = 1, full = 0, count = 0.
  - A reset during an in-flight read discards that read.
- Starvation: continuous non-full writes starve reads. This is documented behaviour, not prevented.

Optional Feature:
- Macro: SP_FIFO_STICKY_ERR_EN.
- Defined: overflow and underflow are sticky; they are set by the event and cleared only by reset or sclr.
- Undefined: they are single-cycle pulses as specified above.

Decomposition:
- Package sp_fifo_pkg holds:
  - access enum: ACC_IDLE, ACC_WR, ACC_RD
  - function fifo_count(wptr, rptr)
  - local constant DEPTH derivation helper
- Sub-module sp_fifo_ram, parameters DATA_W and ADDR_W:
  - ports clk, reset, en, we, addr, din, dout
  - write-first ignored; registered read; dout resets to 0
- The top level holds pointers, arbitration, flags and error logic.

Test Plan:
1. Defaults. After reset, write 0x10..0x17 on 8 consecutive cycles.
   - Expected: wr_ack = 1 each cycle; count 8; full = 1; almost_full from count 6.
   - Then a 9th write of 0xFF: wr_ack = 0, overflow pulse, count stays 8.
2. Read 8 entries from the full state.
   - Expected: rd_valid one cycle after each rd_ack; dout = 0x10..0x17 in order; empty = 1 at the end.
   - An extra read gives an underflow pulse and no rd_valid.
3. count = 3; assert wr_en = rd_en = 1 with din 0xA5.
   - Expected: wr_ack = 1, rd_ack = 0, count 4, rd_valid = 0 next cycle.
   - Then rd_en alone returns the oldest entry.
4. Full FIFO; assert wr_en = rd_en = 1.
   - Expected: rd_ack = 1, overflow pulse, count 7, rd_valid = 1 next cycle with the oldest entry.
5. 40 cycles of random interleaved writes and reads, crossing the pointer wrap at least 3 times.
   - Expected: scoreboard matches in order; count never exceeds 8; full and empty never both 1.
6. count = 5 with a read in flight; assert sclr.
   - Expected next cycle: count 0, empty = 1, rd_valid = 0.
   - Then assert reset mid-write: all outputs return to reset values without waiting for a clock edge.
   - With SP_FIFO_STICKY_ERR_EN defined, overflow stays 1 until sclr.
